// File: rtl/nrisc_pkg.sv
// -----------------------------------------------------------------------------
// nrisc_pkg
// Shared definitions for the nRisc program loader: instruction memory
// geometry, frame sync marker, and the state types of the framing FSM and
// the UART receiver.
// Ports: none (package).
// -----------------------------------------------------------------------------
package nrisc_pkg;

    localparam int         NRISC_IMEM_DEPTH = 128;
    localparam logic [7:0] NRISC_SYNC_BYTE  = 8'hA5;
    localparam int         NRISC_ADDR_W     = 8;

    // Framing FSM: waiting for sync, expecting length, streaming data,
    // expecting checksum.
    typedef enum logic [1:0] {
        IDLE,
        LEN,
        DATA,
        CSUM
    } loader_state_t;

    // UART receiver bit-level phases.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/nrisc_prog_loader_if.sv
// -----------------------------------------------------------------------------
// nrisc_prog_loader_if
// Instruction-memory write bus between the program loader (master) and the
// instruction memory (slave).
// Signals:
//   mem_we     write strobe, one cycle per byte
//   mem_addr   byte address
//   mem_wdata  byte to write
// -----------------------------------------------------------------------------
interface nrisc_prog_loader_if;
    import nrisc_pkg::*;

    logic                    mem_we;
    logic [NRISC_ADDR_W-1:0] mem_addr;
    logic [7:0]              mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);

endinterface

// File: rtl/nrisc_uart_rx.sv
// -----------------------------------------------------------------------------
// nrisc_uart_rx
// 8N1 UART receiver. The raw line is brought into the Clock domain through a
// two-flop synchroniser; a start bit is a synchronised 1->0 edge, re-checked
// half a bit later to reject glitches. Data bits (LSB first) and the stop bit
// are each sampled one full bit period after the previous sample.
// Ports:
//   Clock       system clock
//   Reset       asynchronous, active-high
//   rx          serial input, idle high, asynchronous to Clock
//   byte_valid  one-cycle pulse, cycle after a good stop-bit sample
//   byte_data   received byte, valid while byte_valid is high
//   frame_err   one-cycle pulse instead of byte_valid when the stop bit is 0
// -----------------------------------------------------------------------------
module nrisc_uart_rx
    import nrisc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_meta, rx_sync, rx_prev;

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             valid_next, err_next;

    // Synchroniser (rx_meta, rx_sync) plus one history flop for edge detect.
    // The line idles high, so the flops reset high to avoid a false start.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            byte_valid <= valid_next;
            frame_err  <= err_next;
        end
    end

    // NOTE: every signal written below gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 1'b1;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        valid_next    = 1'b0;
        err_next      = 1'b0;

        unique case (state)
            RX_IDLE: begin
                baud_cnt_next = '0;
                if (rx_prev && !rx_sync) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (baud_cnt == HALF_M1) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    // Line back high at mid-start: a glitch, not a start bit.
                    state_next    = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt == FULL_M1) begin
                    baud_cnt_next = '0;
                    shift_next    = {rx_sync, shift[7:1]};
                    bit_idx_next  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (baud_cnt == FULL_M1) begin
                    state_next = RX_IDLE;
                    valid_next = rx_sync;
                    err_next   = !rx_sync;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // The shifter is frozen outside RX_DATA, so it is stable during byte_valid.
    assign byte_data = shift;

endmodule

// File: rtl/nrisc_prog_loader.sv
// -----------------------------------------------------------------------------
// nrisc_prog_loader
// Serial program loader for the nRisc instruction memory. Parses frames of
// the form SYNC, LEN, LEN data bytes, CSUM from a UART line, writes the data
// bytes to instruction memory from address 0, and keeps the core in reset
// (cpu_hold) until a frame with a valid checksum completes. A sync byte seen
// while the core runs reasserts cpu_hold and starts a reload.
// Checksum: (sum of data bytes + CSUM) mod 256 must be 0.
// Optional build macro NRISC_LOADER_TIMEOUT_EN: aborts a frame with load_err
// when no byte arrives for 64*CLKS_PER_BIT*10 cycles mid-frame. Without it
// the loader waits indefinitely.
// Ports:
//   Clock      system clock
//   Reset      asynchronous, active-high
//   rx         UART serial input (8N1, idle high)
//   imem       instruction-memory write bus (mem_we, mem_addr, mem_wdata)
//   cpu_hold   1 = core held in reset (ORed into the core's Reset)
//   busy       1 while a frame is in progress
//   load_done  one-cycle pulse on a successful load
//   load_err   sticky error flag, cleared by the next sync byte
// -----------------------------------------------------------------------------
module nrisc_prog_loader
    import nrisc_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         MEM_DEPTH    = NRISC_IMEM_DEPTH,
    parameter logic [7:0] SYNC_BYTE    = NRISC_SYNC_BYTE
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                rx,
    nrisc_prog_loader_if.master imem,
    output logic                cpu_hold,
    output logic                busy,
    output logic                load_done,
    output logic                load_err
);

    localparam logic [8:0] MAX_LEN = 9'(MEM_DEPTH);

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    nrisc_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .Clock      (Clock),
        .Reset      (Reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_t           state, state_next;
    logic [NRISC_ADDR_W-1:0] addr_cnt;
    logic [7:0]              sum;
    logic [7:0]              remain;
    logic [7:0]              csum_total;
    logic                    len_bad;
    logic                    timeout;
    logic                    abort;

    logic start_frame, latch_len, do_write, do_done, set_err;

    assign csum_total = sum + byte_data;
    assign len_bad    = (byte_data == 8'd0) || ({1'b0, byte_data} > MAX_LEN);
    // Errors are only meaningful mid-frame; in IDLE a bad stop bit is noise.
    assign abort      = frame_err || timeout;
    assign busy       = (state != IDLE);

`ifdef NRISC_LOADER_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_M1 = 24'(64 * CLKS_PER_BIT * 10 - 1);
    logic [23:0] idle_cnt;

    // Counts cycles since the last received byte while a frame is open.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            idle_cnt <= '0;
        end else if (state == IDLE || byte_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 24'd1;
        end
    end

    assign timeout = (state != IDLE) && (idle_cnt == TIMEOUT_M1);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        latch_len   = 1'b0;
        do_write    = 1'b0;
        do_done     = 1'b0;
        set_err     = 1'b0;

        unique case (state)
            IDLE: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    start_frame = 1'b1;
                    state_next  = LEN;
                end
            end
            LEN: begin
                if (abort) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end else if (byte_valid) begin
                    if (len_bad) begin
                        set_err    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        latch_len  = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (abort) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end else if (byte_valid) begin
                    do_write = 1'b1;
                    if (remain == 8'd1) begin
                        state_next = CSUM;
                    end
                end
            end
            CSUM: begin
                if (abort) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end else if (byte_valid) begin
                    state_next = IDLE;
                    if (csum_total == 8'd0) begin
                        do_done = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered datapath: every action decided in the byte_valid cycle shows
    // on the outputs one cycle later.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            imem.mem_we    <= 1'b0;
            imem.mem_addr  <= '0;
            imem.mem_wdata <= '0;
            cpu_hold       <= 1'b1;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            addr_cnt       <= '0;
            sum            <= '0;
            remain         <= '0;
        end else begin
            imem.mem_we <= do_write;
            load_done   <= do_done;

            if (start_frame) begin
                cpu_hold <= 1'b1;
                load_err <= 1'b0;
                sum      <= '0;
                addr_cnt <= '0;
            end
            if (set_err) begin
                load_err <= 1'b1;
            end
            if (do_done) begin
                cpu_hold <= 1'b0;
            end
            if (latch_len) begin
                remain <= byte_data;
            end
            if (do_write) begin
                imem.mem_addr  <= addr_cnt;
                imem.mem_wdata <= byte_data;
                addr_cnt       <= addr_cnt + 1'b1;
                sum            <= sum + byte_data;
                remain         <= remain - 8'd1;
            end
        end
    end

endmodule

// File: doc/nrisc_prog_loader.md
Name: nrisc_prog_loader

Overview:
- Serial program loader: writer side of the nRisc instruction memory, which the core only ever reads.
- Receives a framed program image over an 8N1 UART line and writes it byte-by-byte into instruction memory from address 0.
- Holds the core in reset (cpu_hold) until a frame with a valid checksum completes.
- Sits beside the core at top level; cpu_hold is ORed into the core's Reset.

Parameters:
- CLKS_PER_BIT, 16, Clock cycles per UART bit; must be >= 4.
- MEM_DEPTH, 128, instruction memory depth in bytes; legal frame length is 1..MEM_DEPTH.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- Clock  input  1  system clock.
- Reset  input  1  reset, asynchronous, active-high.
- rx  input  1  UART serial input, idle high, asynchronous to Clock.
- mem_we  output  1  instruction memory write strobe, one cycle per byte.
- mem_addr  output  8  write address.
- mem_wdata  output  8  write data.
- cpu_hold  output  1  1 = core held in reset.
- busy  output  1  1 while a frame is in progress (state not IDLE).
- load_done  output  1  one-cycle pulse on successful load.
- load_err  output  1  sticky error flag.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, load_done=0, load_err=0. FSM goes to IDLE and the UART RX returns to idle.
- Reset mid-frame aborts the frame. Bytes already written stay in memory. cpu_hold=1.
- RX synchroniser: rx passes through 2 flops before use.
- Start bit: detected on a synchronised 1->0 transition.
- Start re-check: the line is re-sampled at CLKS_PER_BIT/2. If it is high, the start is treated as a glitch and RX returns to idle.
- Bit sampling: 8 data bits LSB-first, each sampled CLKS_PER_BIT after the previous sample. The stop bit is sampled the same way.
- Stop bit = 1: byte_valid pulses for one cycle, with the byte.
- Stop bit = 0: frame_err pulses instead; no byte_valid.
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CSUM.
- CSUM rule: (sum of data bytes + CSUM) mod 256 == 0.
- FSM states: IDLE, LEN, DATA, CSUM.
- IDLE:
  - Byte == SYNC_BYTE -> go to LEN; set cpu_hold=1; clear load_err; clear sum and address to 0.
  - Any other byte is ignored.
  - frame_err is ignored.
- LEN:
  - LEN==0 or LEN>MEM_DEPTH -> set load_err; go to IDLE.
  - Otherwise latch remaining count = LEN and go to DATA.
- DATA, on each byte:
  - Next cycle: mem_we=1, mem_addr=address counter, mem_wdata=byte.
  - sum += byte (8-bit wrap); address counter increments.
  - Count reaches 0 -> go to CSUM.
  - Address never exceeds MEM_DEPTH-1, guaranteed by the LEN check.
- CSUM:
  - (sum+byte)==0 -> load_done pulses the next cycle and cpu_hold drops to 0 that same cycle.
  - Mismatch -> load_err=1 and cpu_hold stays 1.
  - Either way, go to IDLE.
- frame_err in LEN, DATA or CSUM -> load_err=1; go to IDLE; cpu_hold stays 1.
- Reload: a SYNC_BYTE arriving while the core runs (cpu_hold=0) reasserts cpu_hold in the cycle after byte_valid, which starts a reload.
- busy = (state != IDLE).
- mem_we and load_done are never asserted together.
- Latency: byte_valid to mem_we is 1 cycle. Stop-bit sample to byte_valid is 1 cycle.

Optional Feature:
- Macro: NRISC_LOADER_TIMEOUT_EN.
- Defined:
  - A 24-bit idle counter runs in LEN, DATA and CSUM and restarts on every byte_valid.
  - Reaching 64*CLKS_PER_BIT*10 cycles -> load_err=1, go to IDLE, cpu_hold stays 1.
- Undefined: no counter, and the loader waits indefinitely mid-frame.

Decomposition:
- Shared package nrisc_pkg:
  - FSM state enum loader_state_t (IDLE, LEN, DATA, CSUM).
  - Constant NRISC_IMEM_DEPTH=128.
  - Constant NRISC_SYNC_BYTE=8'hA5.
  - Address width constant = 8.
- One sub-module: nrisc_uart_rx.
  - Parameter: CLKS_PER_BIT.
  - Ports: Clock, Reset, rx -> byte_valid, byte_data[7:0], frame_err.
  - Contains the synchroniser, bit counter and baud counter.
- The top module holds the framing FSM, checksum, address counter and optional timeout.

Test Plan (CLKS_PER_BIT=4 for all):
- Good load: send A5, 03, 11, 22, 33, CSUM=9A.
  - Three mem_we pulses: (0,11), (1,22), (2,33).
  - load_done pulses once; cpu_hold 1->0 in the same cycle; load_err=0.
- Bad checksum: same frame with CSUM=9B.
  - Three writes occur; no load_done; load_err=1; cpu_hold=1.
- Illegal length: send A5, 00, then A5, 81 (129).
  - Each sets load_err; no mem_we; FSM returns to IDLE (busy=0).
  - A following good frame clears load_err and loads.
- Framing error: stop bit driven 0 on the second data byte.
  - Exactly one write at address 0; load_err=1; busy=0.
  - A 2-cycle low glitch on rx in IDLE produces no byte.
- Reset mid-frame: assert Reset after the first data byte's write.
  - All outputs return to reset values in the same cycle; cpu_hold=1.
  - A subsequent full frame loads correctly from address 0.
- Reload and timeout:
  - After a good load, send A5 -> cpu_hold=1 the cycle after byte_valid.
  - With NRISC_LOADER_TIMEOUT_EN, stalling 2560 cycles after LEN -> load_err=1, busy=0.
